// File: rtl/mem_align_unit_pkg.sv
// Shared definitions for mem_align_unit: DMType codes, FSM state encodings
// and the misalignment rule used by both the split and trap builds.
package mem_align_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  // DMType codes, identical to those in ctrl_encode_def.v
  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] dm_type, input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    case (dm_type)
      DM_WORD:                           mis = (lsb != 2'd0);
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: mis = (lsb == 2'd3);
      default:                           mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Index of the final byte of a split access (N-1).
  function automatic logic [CNT_W-1:0] last_idx(input logic [2:0] dm_type);
    return (dm_type == DM_WORD) ? CNT_W'(3) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_align_unit_load_ext.sv
// Pure combinational sign/zero extension of an assembled 32-bit load value
// according to its DMType code.
module load_ext
  import mem_align_unit_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (dm_type)
      DM_WORD:              ext = raw;
      DM_HALFWORD:          ext = {{16{raw[15]}}, raw[15:0]};
      DM_HALFWORD_UNSIGNED: ext = {16'b0, raw[15:0]};
      DM_BYTE:              ext = {{24{raw[7]}}, raw[7:0]};
      DM_BYTE_UNSIGNED:     ext = {24'b0, raw[7:0]};
      default:              ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// Alignment unit between EX/MEM and data memory: aligned accesses pass through,
// misaligned ones are split into byte accesses (or trapped when MISALIGN_TRAP_EN).
module mem_align_unit
  import mem_align_unit_pkg::*;
#(
  parameter int XLEN  = mem_align_unit_pkg::XLEN,
  parameter int CNT_W = mem_align_unit_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_type,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0] req_pc,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            dm_wr,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_din,
  output logic [2:0]      dm_type,
  output logic [XLEN-1:0] dm_pc,
  input  logic [XLEN-1:0] dm_dout
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc
`endif
);

  // Handshake: req_valid qualifies req_*; there is no ready, back-pressure is
  // via stall, which holds EX/MEM steady until the access completes.
  logic            req_mis;
  logic            dm_wr_raw;
  logic            stall_raw;
  logic            resp_valid_raw;
  logic [2:0]      ext_type;
  logic [XLEN-1:0] ext_raw;
  logic [XLEN-1:0] ext_val;

  assign req_mis = req_valid & is_misaligned(req_type, req_addr[1:0]);

  load_ext u_load_ext (
    .dm_type (ext_type),
    .raw     (ext_raw),
    .ext     (ext_val)
  );

`ifdef MISALIGN_TRAP_EN

  always_comb begin
    dm_addr        = req_addr;
    dm_din         = req_wdata;
    dm_type        = req_type;
    dm_pc          = req_pc;
    ext_type       = req_type;
    ext_raw        = dm_dout;
    stall_raw      = 1'b0;
    dm_wr_raw      = req_valid & req_we & ~req_mis;
    resp_valid_raw = req_valid & ~req_we & ~req_mis;
  end

  // Combinational pulse; the exception path registers it downstream.
  assign misalign_exc = rstn & req_mis;

`else

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [23:0]      byte_buf, byte_buf_nxt;
  logic [XLEN-1:0]  addr_q, wdata_q, pc_q;
  logic             we_q;
  logic [2:0]       type_q;
  logic             latch_en;
  logic [7:0]       wbyte_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      byte_buf <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      we_q     <= 1'b0;
      type_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      byte_buf <= byte_buf_nxt;
      if (latch_en) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
        we_q    <= req_we;
        type_q  <= req_type;
      end
    end
  end

  always_comb begin
    wbyte_q = wdata_q[7:0];
    case (cnt)
      2'd0:    wbyte_q = wdata_q[7:0];
      2'd1:    wbyte_q = wdata_q[15:8];
      2'd2:    wbyte_q = wdata_q[23:16];
      default: wbyte_q = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    byte_buf_nxt   = byte_buf;
    latch_en       = 1'b0;
    dm_addr        = req_addr;
    dm_din         = req_wdata;
    dm_type        = req_type;
    dm_pc          = req_pc;
    dm_wr_raw      = req_valid & req_we;
    stall_raw      = 1'b0;
    resp_valid_raw = req_valid & ~req_we;
    ext_type       = req_type;
    ext_raw        = dm_dout;

    case (state)
      ST_IDLE: begin
        if (req_mis) begin
          // Byte 0 goes out in the request cycle itself.
          dm_type        = DM_BYTE_UNSIGNED;
          dm_din         = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
          dm_wr_raw      = req_we;
          stall_raw      = 1'b1;
          resp_valid_raw = 1'b0;
          latch_en       = 1'b1;
          cnt_nxt        = CNT_W'(1);
          byte_buf_nxt   = req_we ? 24'b0 : {16'b0, dm_dout[7:0]};
          state_nxt      = ST_SPLIT;
        end
      end

      ST_SPLIT: begin
        dm_addr        = addr_q + XLEN'(cnt);
        dm_type        = DM_BYTE_UNSIGNED;
        dm_din         = {{(XLEN-8){1'b0}}, wbyte_q};
        dm_pc          = pc_q;
        dm_wr_raw      = we_q;
        resp_valid_raw = 1'b0;
        ext_type       = type_q;
        if (cnt == last_idx(type_q)) begin
          resp_valid_raw = ~we_q;
          ext_raw        = (type_q == DM_WORD) ? {dm_dout[7:0], byte_buf}
                                               : {16'b0, dm_dout[7:0], byte_buf[7:0]};
          cnt_nxt        = '0;
          byte_buf_nxt   = '0;
          state_nxt      = ST_IDLE;
        end else begin
          stall_raw = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          if (!we_q) begin
            case (cnt)
              2'd0:    byte_buf_nxt[7:0]   = dm_dout[7:0];
              2'd1:    byte_buf_nxt[15:8]  = dm_dout[7:0];
              default: byte_buf_nxt[23:16] = dm_dout[7:0];
            endcase
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

`endif

  // Reset masks every control output immediately, even mid-split.
  assign dm_wr      = rstn & dm_wr_raw;
  assign stall      = rstn & stall_raw;
  assign resp_valid = rstn & resp_valid_raw;
  assign resp_rdata = resp_valid ? ext_val : '0;

endmodule
